// File: rtl/frame_fifo_pkg.sv
// frame_fifo_pkg: shared definitions for the frame-aware FIFO.
//   - default parameter values for frame_fifo
//   - entry_t: one stored beat {last, data} at the default payload width
//   - ptr_diff: modular pointer difference, truncated by the caller to the
//     pointer width in use
package frame_fifo_pkg;

    localparam int FF_DATA_W    = 8;
    localparam int FF_DEPTH     = 64;
    localparam int FF_AF_THRESH = FF_DEPTH - 4;

    // Wide enough for any pointer this FIFO can be built with.
    localparam int PTR_MAX_W    = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

    typedef struct packed {
        logic                 last;
        logic [FF_DATA_W-1:0] data;
    } entry_t;

    // Both pointers are zero-extended before the subtraction, so the low
    // ADDR_W+1 bits of the result are the difference modulo 2*DEPTH.
    function automatic ptr_wide_t ptr_diff(input ptr_wide_t a, input ptr_wide_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port DEPTH x WIDTH storage array.
// Synchronous write. The read port is either registered (SYNC_RD=1, updates
// on i_re and resets to 0) or asynchronous (SYNC_RD=0). o_peek always shows
// the asynchronous view of the read address.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset (read register only)
//   i_we, i_waddr, i_wdata write port
//   i_re, i_raddr         read enable (registered mode) and read address
//   o_rdata               read data in the selected mode
//   o_peek                combinational mem[i_raddr]
module fifo_ram #(
    parameter int WIDTH   = 9,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter bit SYNC_RD = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata,
    output logic [WIDTH-1:0]  o_peek
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_async;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign w_async = r_mem[i_raddr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= w_async;
        end
    end

    assign o_rdata = SYNC_RD ? r_q : w_async;
    assign o_peek  = w_async;

endmodule

// File: rtl/frame_fifo.sv
// frame_fifo: synchronous FIFO with Ethernet frame awareness.
// Beats are written speculatively (wr_ptr) and become visible to the reader
// only when the frame's last beat commits them (cm_ptr). A frame can be
// discarded with i_wr_drop; a frame that overflows is truncated and dropped
// automatically once its last beat arrives.
// Build option: define FRAME_FIFO_FWFT_EN for first-word-fall-through reads
// (o_data_out shows the head entry combinationally); otherwise reads have
// one cycle of latency and the output holds until the next accepted read.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_write, i_data_in, i_wr_last  write beat and end-of-frame tag
//   i_wr_drop                      discard the uncommitted frame
//   i_read                         read request / pop
//   o_data_out, o_rd_last          read beat and its end-of-frame tag
//   o_full, o_almost_full          space flags (include uncommitted beats)
//   o_empty, o_level               committed beats available to the reader
//   o_frame_cnt                    complete frames stored
//   o_overflow, o_underflow        sticky error flags, cleared by i_err_clr
module frame_fifo
    import frame_fifo_pkg::*;
#(
    parameter int DATA_W    = FF_DATA_W,
    parameter int DEPTH     = FF_DEPTH,
    parameter int AF_THRESH = FF_AF_THRESH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_write,
    input  logic [DATA_W-1:0]          i_data_in,
    input  logic                       i_wr_last,
    input  logic                       i_wr_drop,
    input  logic                       i_read,
    output logic [DATA_W-1:0]          o_data_out,
    output logic                       o_rd_last,
    output logic                       o_full,
    output logic                       o_almost_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [$clog2(DEPTH):0]     o_frame_cnt,
    output logic                       o_overflow,
    output logic                       o_underflow,
    input  logic                       i_err_clr
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [ADDR_W:0] ptr_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_w_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);

`ifdef FRAME_FIFO_FWFT_EN
    localparam bit SYNC_RD = 1'b0;
`else
    localparam bit SYNC_RD = 1'b1;
`endif

    ptr_t     r_wr_ptr;
    ptr_t     r_cm_ptr;
    ptr_t     r_rd_ptr;
    ptr_t     r_frame_cnt;
    logic     r_drop_pend;
    logic     r_overflow;
    logic     r_underflow;

    ptr_t     w_occupancy;
    ptr_t     w_level;
    logic     w_full;
    logic     w_empty;
    logic     w_wr_acc;
    logic     w_wr_ovf;
    logic     w_rd_acc;
    logic     w_rd_udf;
    logic     w_commit;
    logic     w_pop_last;
    entry_w_t w_wr_entry;
    entry_w_t w_rd_entry;
    entry_w_t w_peek;

    assign w_occupancy = ptr_t'(ptr_diff(ptr_wide_t'(r_wr_ptr), ptr_wide_t'(r_rd_ptr)));
    assign w_level     = ptr_t'(ptr_diff(ptr_wide_t'(r_cm_ptr), ptr_wide_t'(r_rd_ptr)));
    assign w_full      = (w_occupancy == ptr_t'(DEPTH));
    assign w_empty     = (w_level == '0);

    // A drop request or an in-progress truncated frame blocks every write.
    assign w_wr_acc   = i_write && !w_full && !r_drop_pend && !i_wr_drop;
    assign w_wr_ovf   = i_write &&  w_full && !r_drop_pend && !i_wr_drop;
    assign w_rd_acc   = i_read && !w_empty;
    assign w_rd_udf   = i_read &&  w_empty;
    assign w_commit   = w_wr_acc && i_wr_last;
    assign w_pop_last = w_rd_acc && w_peek.last;

    assign w_wr_entry.last = i_wr_last;
    assign w_wr_entry.data = i_data_in;

    fifo_ram #(
        .WIDTH   (DATA_W + 1),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .SYNC_RD (SYNC_RD)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (w_wr_entry),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rd_entry),
        .o_peek  (w_peek)
    );

    // Write side: speculative and committed pointers, truncation handling.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_cm_ptr    <= '0;
            r_drop_pend <= 1'b0;
        end else if (i_wr_drop) begin
            r_wr_ptr    <= r_cm_ptr;
            r_drop_pend <= 1'b0;
        end else if (r_drop_pend) begin
            // Swallow the rest of the truncated frame; its last beat rewinds.
            if (i_write && i_wr_last) begin
                r_wr_ptr    <= r_cm_ptr;
                r_drop_pend <= 1'b0;
            end
        end else if (w_wr_ovf) begin
            // A lost single-beat frame leaves nothing behind to discard.
            if ((r_wr_ptr != r_cm_ptr) || !i_wr_last) begin
                r_drop_pend <= 1'b1;
            end
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_wr_last) begin
                r_cm_ptr <= r_wr_ptr + PTR_ONE;
            end
        end
    end

    // Read side, frame counter and sticky errors.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr    <= '0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_commit, w_pop_last})
                2'b10:   r_frame_cnt <= r_frame_cnt + PTR_ONE;
                2'b01:   r_frame_cnt <= r_frame_cnt - PTR_ONE;
                default: r_frame_cnt <= r_frame_cnt;
            endcase
            // A new error event in the clearing cycle keeps the flag set.
            r_overflow  <= w_wr_ovf || (r_overflow  && !i_err_clr);
            r_underflow <= w_rd_udf || (r_underflow && !i_err_clr);
        end
    end

`ifdef FRAME_FIFO_FWFT_EN
    assign o_data_out = w_empty ? '0 : w_rd_entry.data;
    assign o_rd_last  = !w_empty && w_rd_entry.last;
`else
    assign o_data_out = w_rd_entry.data;
    assign o_rd_last  = w_rd_entry.last;
`endif

    assign o_full        = w_full;
    assign o_almost_full = (w_occupancy >= ptr_t'(AF_THRESH));
    assign o_empty       = w_empty;
    assign o_level       = w_level;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_frame_fifo.sv
module tb_frame_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       write;
    logic [7:0] data_in;
    logic       wr_last;
    logic       wr_drop;
    logic       read;
    logic [7:0] data_out;
    logic       rd_last;
    logic       full;
    logic       almost_full;
    logic       empty;
    logic [4:0] level;
    logic [4:0] frame_cnt;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int checks = 0;
    int errors = 0;

    frame_fifo #(
        .DATA_W    (8),
        .DEPTH     (16),
        .AF_THRESH (12)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_write       (write),
        .i_data_in     (data_in),
        .i_wr_last     (wr_last),
        .i_wr_drop     (wr_drop),
        .i_read        (read),
        .o_data_out    (data_out),
        .o_rd_last     (rd_last),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_empty       (empty),
        .o_level       (level),
        .o_frame_cnt   (frame_cnt),
        .o_overflow    (overflow),
        .o_underflow   (underflow),
        .i_err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic l);
        write = 1'b1; data_in = d; wr_last = l;
        tick();
        write = 1'b0; wr_last = 1'b0;
    endtask

    task automatic rd();
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if ({full, almost_full} !== 2'b00) begin errors++; $display("FAIL reset_full_af got %b exp 00", {full, almost_full}); end
        checks++; if ({level, frame_cnt} !== 10'd0) begin errors++; $display("FAIL reset_level_fc got %0d/%0d exp 0/0", level, frame_cnt); end
        checks++; if ({data_out, rd_last} !== 9'd0) begin errors++; $display("FAIL reset_dout got %h/%b exp 00/0", data_out, rd_last); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp;
        for (int i = 1; i <= 3; i++) wr(8'(i), 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_uncommitted got %b exp 1", empty); end
        wr(8'h04, 1'b1);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty_committed got %b exp 0", empty); end
        checks++; if (level !== 5'd4) begin errors++; $display("FAIL basic_level got %0d exp 4", level); end
        checks++; if (frame_cnt !== 5'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 1", frame_cnt); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            rd();
            checks++; if ({data_out, rd_last} !== {exp, (i == 4)}) begin
                errors++; $display("FAIL basic_read%0d got %h/%b exp %h/%b", i, data_out, rd_last, exp, (i == 4));
            end
        end
        checks++; if ({empty, frame_cnt} !== {1'b1, 5'd0}) begin errors++; $display("FAIL basic_drained got %b/%0d exp 1/0", empty, frame_cnt); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL basic_no_underflow got %b exp 0", underflow); end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 3; i++) wr(8'hC0 + 8'(i), 1'b0);
        checks++; if ({empty, level} !== {1'b1, 5'd0}) begin errors++; $display("FAIL drop_uncommitted got %b/%0d exp 1/0", empty, level); end
        rd();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drop_underflow got %b exp 1", underflow); end
        checks++; if (data_out !== 8'h04) begin errors++; $display("FAIL drop_dout_hold got %h exp 04", data_out); end
        wr_drop = 1'b1; tick(); wr_drop = 1'b0;
        checks++; if ({full, level, empty} !== {1'b0, 5'd0, 1'b1}) begin errors++; $display("FAIL drop_rewind got %b/%0d/%b exp 0/0/1", full, level, empty); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drop_err_clr got %b exp 0", underflow); end
    endtask

    task automatic test_full();
        logic [7:0] exp;
        for (int i = 1; i <= 16; i++) begin
            wr(8'h0F + 8'(i), (i == 16));
            if (i == 11) begin
                checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL full_af11 got %b exp 0", almost_full); end
            end
            if (i == 12) begin
                checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_af12 got %b exp 1", almost_full); end
            end
            if (i == 15) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at15 got %b exp 0", full); end
            end
        end
        checks++; if ({full, level, frame_cnt} !== {1'b1, 5'd16, 5'd1}) begin errors++; $display("FAIL full_at16 got %b/%0d/%0d exp 1/16/1", full, level, frame_cnt); end
        wr(8'hEE, 1'b1);
        checks++; if ({overflow, level, frame_cnt} !== {1'b1, 5'd16, 5'd1}) begin errors++; $display("FAIL full_overflow got %b/%0d/%0d exp 1/16/1", overflow, level, frame_cnt); end
        err_clr = 1'b1; wr(8'hEF, 1'b1); err_clr = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_clr_vs_event got %b exp 1", overflow); end
        for (int i = 1; i <= 16; i++) begin
            exp = 8'h0F + 8'(i);
            rd();
            checks++; if ({data_out, rd_last} !== {exp, (i == 16)}) begin
                errors++; $display("FAIL full_read%0d got %h/%b exp %h/%b", i, data_out, rd_last, exp, (i == 16));
            end
        end
        checks++; if ({empty, frame_cnt} !== {1'b1, 5'd0}) begin errors++; $display("FAIL full_drained got %b/%0d exp 1/0", empty, frame_cnt); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_err_clr got %b exp 0", overflow); end
    endtask

    task automatic test_truncate();
        logic [7:0] exp;
        for (int i = 1; i <= 10; i++) wr(8'h2F + 8'(i), (i == 10));
        checks++; if ({level, frame_cnt} !== {5'd10, 5'd1}) begin errors++; $display("FAIL trunc_first got %0d/%0d exp 10/1", level, frame_cnt); end
        for (int i = 1; i <= 6; i++) wr(8'h4F + 8'(i), 1'b0);
        checks++; if ({full, overflow} !== 2'b10) begin errors++; $display("FAIL trunc_full got %b/%b exp 1/0", full, overflow); end
        wr(8'h57, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL trunc_overflow got %b exp 1", overflow); end
        wr(8'h58, 1'b1);
        checks++; if ({full, level, frame_cnt} !== {1'b0, 5'd10, 5'd1}) begin errors++; $display("FAIL trunc_rewind got %b/%0d/%0d exp 0/10/1", full, level, frame_cnt); end
        for (int i = 1; i <= 10; i++) begin
            exp = 8'h2F + 8'(i);
            rd();
            checks++; if ({data_out, rd_last} !== {exp, (i == 10)}) begin
                errors++; $display("FAIL trunc_read%0d got %h/%b exp %h/%b", i, data_out, rd_last, exp, (i == 10));
            end
        end
        checks++; if ({empty, frame_cnt} !== {1'b1, 5'd0}) begin errors++; $display("FAIL trunc_drained got %b/%0d exp 1/0", empty, frame_cnt); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        wr(8'h61, 1'b1);
        checks++; if ({level, frame_cnt} !== {5'd1, 5'd1}) begin errors++; $display("FAIL b2b_first got %0d/%0d exp 1/1", level, frame_cnt); end
        read = 1'b1; wr(8'h62, 1'b1); read = 1'b0;
        checks++; if ({data_out, rd_last} !== {8'h61, 1'b1}) begin errors++; $display("FAIL b2b_read got %h/%b exp 61/1", data_out, rd_last); end
        checks++; if ({level, frame_cnt} !== {5'd1, 5'd1}) begin errors++; $display("FAIL b2b_fc_same got %0d/%0d exp 1/1", level, frame_cnt); end
        rd();
        checks++; if ({data_out, rd_last, frame_cnt, empty} !== {8'h62, 1'b1, 5'd0, 1'b1}) begin
            errors++; $display("FAIL b2b_second got %h/%b/%0d/%b exp 62/1/0/1", data_out, rd_last, frame_cnt, empty);
        end
    endtask

    task automatic test_mid_reset();
        rd();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mrst_underflow got %b exp 1", underflow); end
        wr(8'h71, 1'b1);
        wr(8'h72, 1'b0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if ({empty, level, frame_cnt} !== {1'b1, 5'd0, 5'd0}) begin errors++; $display("FAIL mrst_ptrs got %b/%0d/%0d exp 1/0/0", empty, level, frame_cnt); end
        checks++; if ({data_out, rd_last} !== 9'd0) begin errors++; $display("FAIL mrst_dout got %h/%b exp 00/0", data_out, rd_last); end
        checks++; if ({full, almost_full, overflow, underflow} !== 4'b0000) begin
            errors++; $display("FAIL mrst_flags got %b exp 0000", {full, almost_full, overflow, underflow});
        end
    endtask

    task automatic test_fwft();
        wr(8'hA5, 1'b1);
        checks++; if ({data_out, rd_last} !== {8'hA5, 1'b1}) begin errors++; $display("FAIL fwft_show got %h/%b exp a5/1", data_out, rd_last); end
        rd();
        checks++; if ({empty, data_out, rd_last} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL fwft_pop got %b/%h/%b exp 1/00/0", empty, data_out, rd_last); end
    endtask

    initial begin
        rst_n = 1'b0; write = 1'b0; data_in = '0; wr_last = 1'b0;
        wr_drop = 1'b0; read = 1'b0; err_clr = 1'b0;
        test_reset();
`ifdef FRAME_FIFO_FWFT_EN
        test_fwft();
`else
        test_basic_frame();
        test_drop();
        test_full();
        test_truncate();
        test_back_to_back();
        test_mid_reset();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
